// File: rtl/sdu_uart_pkg.sv
// Shared types and timing helpers for the SDU oversampling UART receiver.
package sdu_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } rx_state_e;

    localparam int unsigned OsrDefault = 16;

    // Three samples straddle the bit centre: OSR/2-2, OSR/2-1, OSR/2 (idx 0..2).
    function automatic int unsigned sample_point(input int unsigned osr, input int unsigned idx);
        return osr / 2 - 2 + idx;
    endfunction

endpackage

// File: rtl/sdu_uart_rx_if.sv
// Received-byte stream from the UART receiver to its consumer (valid/ready).
interface sdu_uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/sdu_sync_fifo.sv
// Small first-word-fall-through FIFO; head entry is visible on dout with no read latency.
module sdu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts push & pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sdu_uart_rx.sv
// Oversampling 8N1 UART receiver: synchroniser, 2-of-3 bit voting, framing FSM and
// a receive FIFO presenting a valid/ready byte stream to the SDU command parser.
module sdu_uart_rx
    import sdu_uart_pkg::*;
#(
    parameter int unsigned OSR        = OsrDefault,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    sdu_uart_rx_if.master                 rx_out,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int unsigned CntW = $clog2(OSR);
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CntW-1:0] CntSampleA = CntW'(sample_point(OSR, 0));
    localparam logic [CntW-1:0] CntSampleB = CntW'(sample_point(OSR, 1));
    localparam logic [CntW-1:0] CntResolve = CntW'(sample_point(OSR, 2));
    localparam logic [CntW-1:0] CntLast    = CntW'(OSR - 1);
    localparam logic [IdxW-1:0] IdxLast    = IdxW'(DATA_BITS - 1);

    logic                 rx_meta_q;
    logic                 rxs_q;
    logic                 rxs_prev_q;

    rx_state_e            state_q;
    logic [CntW-1:0]      cnt_q;
    logic [IdxW-1:0]      idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 samp_a_q;
    logic                 samp_b_q;

    logic                 fall;
    logic                 at_resolve;
    logic                 at_last;
    logic                 maj;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Idle-high line: synchroniser and edge history reset to 1 so reset is not a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    always_comb begin
        fall       = rxs_prev_q & ~rxs_q;
        at_resolve = (cnt_q == CntResolve);
        at_last    = (cnt_q == CntLast);
        maj        = (samp_a_q & samp_b_q) | (samp_a_q & rxs_q) | (samp_b_q & rxs_q);
        push       = (state_q == StStop) && at_resolve && maj;
    end

    assign busy              = (state_q != StIdle);
    assign rx_out.dout_valid = ~fifo_empty;
    assign pop               = ~fifo_empty & rx_out.dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            samp_a_q  <= 1'b1;
            samp_b_q  <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (cnt_q == CntSampleA) begin
                samp_a_q <= rxs_q;
            end
            if (cnt_q == CntSampleB) begin
                samp_b_q <= rxs_q;
            end

            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (fall) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (at_resolve && maj) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (at_last) begin
                        state_q <= StData;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (at_resolve) begin
                        shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                    end
                    if (at_last) begin
                        cnt_q <= '0;
                        if (idx_q == IdxLast) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (at_resolve) begin
                        cnt_q <= '0;
                        if (maj) begin
                            // A short stop bit can put the next start edge in this very cycle.
                            state_q <= fall ? StStart : StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= StWaitIdle;
                        end
                    end
                end
                StWaitIdle: begin
                    cnt_q <= '0;
                    if (rxs_q) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Set wins over clear; framing-error frames never push, so they never set overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    sdu_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shreg_q),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (rx_out.dout),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

endmodule

// File: tb/tb_sdu_uart_rx.sv
// Directed bench for sdu_uart_rx at OSR=16: framing, false starts, framing errors,
// FIFO overrun/full behaviour, short stop bits, glitch voting and mid-frame reset.
module tb_sdu_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       ovr_clr = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] fifo_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int valid_cnt = 0;
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];

    sdu_uart_rx_if #(.DATA_BITS(8)) dut_if ();

    sdu_uart_rx #(
        .OSR        (16),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_out    (dut_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .busy      (busy),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream observer, sampled half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (dut_if.dout_valid && dut_if.dout_ready) begin
                rx_q.push_back(dut_if.dout);
                rx_cyc_q.push_back(cyc);
            end
            if (dut_if.dout_valid) valid_cnt <= valid_cnt + 1;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive v for n sampling edges; always returns 1 time unit after a posedge.
    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // g_bit: 0 = start, 1..8 = data bits, 9 = stop; -1 = no glitch.
    task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val,
                              input int g_bit, input int g_off);
        logic v;
        int   len;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) v = 1'b0;
            else if (i == 9) v = stop_val;
            else v = b[i-1];
            len = (i == 9) ? stop_len : 16;
            if (i == g_bit) begin
                hold(v, g_off);
                hold(~v, 1);
                hold(v, len - g_off - 1);
            end else begin
                hold(v, len);
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 16, 1'b1, -1, 0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_if.dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", dut_if.dout_valid);
        end
        checks++;
        if (fifo_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", fifo_cnt);
        end
        checks++;
        if ({frame_err, overrun, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {frame_err, overrun, busy});
        end
        rst = 1'b0;
        hold(1'b1, 8);
    endtask

    task automatic test_frames;
        int base, start, f0, v0;
        base = rx_q.size(); f0 = ferr_cnt; v0 = valid_cnt;
        start = cyc;
        send(8'h55);
        send(8'hA3);
        hold(1'b1, 4);
        checks++;
        if (rx_q.size() - base != 2) begin
            errors++; $display("FAIL frames_count got %0d want 2", rx_q.size() - base);
        end else begin
            checks++;
            if (rx_q[base] !== 8'h55 || rx_q[base+1] !== 8'hA3) begin
                errors++;
                $display("FAIL frames_data got %h %h want 55 a3", rx_q[base], rx_q[base+1]);
            end
            // 155 clk from the edge that first samples the low pin, plus the drive cycle.
            checks++;
            if (rx_cyc_q[base] - start != 156) begin
                errors++;
                $display("FAIL frames_latency got %0d want 156", rx_cyc_q[base] - start);
            end
        end
        checks++;
        if (valid_cnt - v0 != 2) begin
            errors++; $display("FAIL frames_valid_cycles got %0d want 2", valid_cnt - v0);
        end
        checks++;
        if (ferr_cnt != f0) begin
            errors++; $display("FAIL frames_ferr got %0d want %0d", ferr_cnt, f0);
        end
    endtask

    task automatic test_false_start;
        int base;
        base = rx_q.size();
        hold(1'b0, 3);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL false_start_busy_on got %b want 1", busy);
        end
        hold(1'b1, 9);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL false_start_busy_off got %b want 0", busy);
        end
        hold(1'b1, 10);
        hold(1'b0, 1);
        hold(1'b1, 24);
        checks++;
        if (rx_q.size() != base || fifo_cnt !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL false_start_nobyte got n=%0d cnt=%0d busy=%b want 0 0 0",
                     rx_q.size() - base, fifo_cnt, busy);
        end
    endtask

    task automatic test_frame_error;
        int base, f0;
        base = rx_q.size(); f0 = ferr_cnt;
        send_frame(8'h3C, 16, 1'b0, -1, 0);
        hold(1'b0, 40);
        checks++;
        if (ferr_cnt - f0 != 1) begin
            errors++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt - f0);
        end
        checks++;
        if (busy !== 1'b1 || fifo_cnt !== 3'd0) begin
            errors++; $display("FAIL ferr_hold got busy=%b cnt=%0d want 1 0", busy, fifo_cnt);
        end
        hold(1'b1, 4);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ferr_release got busy=%b want 0", busy);
        end
        send(8'h7E);
        hold(1'b1, 4);
        checks++;
        if (rx_q.size() - base != 1 || rx_q[rx_q.size()-1] !== 8'h7E) begin
            errors++;
            $display("FAIL ferr_next got n=%0d last=%h want 1 7e", rx_q.size() - base,
                     rx_q[rx_q.size()-1]);
        end
        checks++;
        if (ferr_cnt - f0 != 1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ferr_after got ferr=%0d ovr=%b want 1 0", ferr_cnt - f0, overrun);
        end
    endtask

    task automatic test_overrun;
        int base;
        dut_if.dout_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i));
        hold(1'b1, 4);
        checks++;
        if (fifo_cnt !== 3'd4 || overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_fill got cnt=%0d ovr=%b want 4 0", fifo_cnt, overrun);
        end
        send(8'h05);
        hold(1'b1, 4);
        checks++;
        if (fifo_cnt !== 3'd4 || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_set got cnt=%0d ovr=%b want 4 1", fifo_cnt, overrun);
        end
        checks++;
        if (dut_if.dout_valid !== 1'b1 || dut_if.dout !== 8'h01) begin
            errors++;
            $display("FAIL ovr_head got v=%b d=%h want 1 01", dut_if.dout_valid, dut_if.dout);
        end
        base = rx_q.size();
        dut_if.dout_ready = 1'b1;
        hold(1'b1, 8);
        checks++;
        if (rx_q.size() - base != 4) begin
            errors++; $display("FAIL ovr_drain_count got %0d want 4", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[base+i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL ovr_drain_%0d got %h want %h", i, rx_q[base+i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (fifo_cnt !== 3'd0 || overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky got cnt=%0d ovr=%b want 0 1", fifo_cnt, overrun);
        end
        ovr_clr = 1'b1;
        hold(1'b1, 1);
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_clear got %b want 0", overrun);
        end
    endtask

    task automatic test_full_push_pop;
        int base;
        logic [7:0] exp [4];
        exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44; exp[3] = 8'h06;
        dut_if.dout_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        hold(1'b1, 4);
        base = rx_q.size();
        // Open ready for exactly the STOP resolve cycle of the next frame.
        fork
            send(8'h06);
            begin
                repeat (155) @(posedge clk);
                #1;
                dut_if.dout_ready = 1'b1;
                @(posedge clk);
                #1;
                dut_if.dout_ready = 1'b0;
            end
        join
        checks++;
        if (fifo_cnt !== 3'd4 || overrun !== 1'b0) begin
            errors++; $display("FAIL fpp_state got cnt=%0d ovr=%b want 4 0", fifo_cnt, overrun);
        end
        checks++;
        if (rx_q.size() - base != 1 || rx_q[base] !== 8'h11) begin
            errors++;
            $display("FAIL fpp_pop got n=%0d d=%h want 1 11", rx_q.size() - base, rx_q[base]);
        end
        base = rx_q.size();
        dut_if.dout_ready = 1'b1;
        hold(1'b1, 8);
        checks++;
        if (rx_q.size() - base != 4) begin
            errors++; $display("FAIL fpp_drain_count got %0d want 4", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL fpp_drain_%0d got %h want %h", i, rx_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int base, f0;
        logic [7:0] exp [3];
        exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h80;
        base = rx_q.size(); f0 = ferr_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 9, 1'b1, -1, 0);
        hold(1'b1, 20);
        checks++;
        if (rx_q.size() - base != 3 || ferr_cnt != f0) begin
            errors++;
            $display("FAIL b2b_count got n=%0d ferr=%0d want 3 0", rx_q.size() - base,
                     ferr_cnt - f0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL b2b_%0d got %h want %h", i, rx_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int base, f0;
        logic [7:0] exp [3];
        exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = 8'hC3;
        base = rx_q.size(); f0 = ferr_cnt;
        send_frame(exp[0], 16, 1'b1, 3, 8);
        send_frame(exp[1], 16, 1'b1, 0, 9);
        send_frame(exp[2], 16, 1'b1, 9, 7);
        hold(1'b1, 4);
        checks++;
        if (rx_q.size() - base != 3 || ferr_cnt != f0) begin
            errors++;
            $display("FAIL glitch_count got n=%0d ferr=%0d want 3 0", rx_q.size() - base,
                     ferr_cnt - f0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL glitch_%0d got %h want %h", i, rx_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        dut_if.dout_ready = 1'b0;
        send(8'h12);
        send(8'h34);
        hold(1'b1, 4);
        checks++;
        if (fifo_cnt !== 3'd2) begin
            errors++; $display("FAIL rstmid_fill got %0d want 2", fifo_cnt);
        end
        // 0x5A LSB first: start, 0, 1, then reset halfway through bit 2.
        hold(1'b0, 16);
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 8);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy got %b want 1", busy);
        end
        rst = 1'b1;
        hold(1'b1, 2);
        checks++;
        if (dut_if.dout_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_fifo got v=%b cnt=%0d want 0 0", dut_if.dout_valid, fifo_cnt);
        end
        checks++;
        if ({frame_err, overrun, busy} !== 3'b000) begin
            errors++; $display("FAIL rstmid_flags got %b want 000", {frame_err, overrun, busy});
        end
        rst = 1'b0;
        hold(1'b1, 20);
        base = rx_q.size();
        dut_if.dout_ready = 1'b1;
        send(8'h99);
        hold(1'b1, 8);
        checks++;
        if (rx_q.size() - base != 1 || rx_q[base] !== 8'h99) begin
            errors++;
            $display("FAIL rstmid_next got n=%0d d=%h want 1 99", rx_q.size() - base, rx_q[base]);
        end
    endtask

    initial begin
        dut_if.dout_ready = 1'b1;
        test_reset();
        test_frames();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
